// File: rtl/data_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and default sizes for the data-memory arbiter.
//   - arb_state_t : which requester currently has priority.
//   - rd_owner_t  : which requester owns the read data returning next cycle.
//   - DEF_*       : default widths / fairness bound used by the arbiter.
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_IDX_W    = 10;  // 1024-word memory
  localparam int DEF_MAX_WAIT = 4;

  typedef enum logic [0:0] {
    ARB_CPU = 1'b0,   // CPU has priority
    ARB_EXT = 1'b1    // EXT has been starved long enough; it goes first
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
//   Bundles the CPU port, EXT port and data-memory side of the arbiter.
//   modport slave  : the arbiter's view (requests in, grants/data/memory out).
//   modport master : everything around it (requesters plus the memory).
//   CPU  : cpu_req/we/addr/wdata in, cpu_stall/rvalid/rdata out.
//   EXT  : ext_req/we/addr/wdata in, ext_gnt/rvalid/rdata out.
//   MEM  : mem_write/address/write_data out, mem_read_data in.
//   addr_err : sticky illegal-address flag.
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  logic              addr_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_write, mem_address, mem_write_data,
    input  mem_read_data,
    output addr_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_write, mem_address, mem_write_data,
    output mem_read_data,
    input  addr_err
  );

endinterface

// File: rtl/data_mem_arbiter_addr_check.sv
// ---------------------------------------------------------------------------
// dmem_addr_check
//   Combinational legality check of one byte address against a word-aligned,
//   2**IDX_W-word memory.
//   addr    in  byte address
//   illegal out 1 when addr is misaligned or lies beyond the memory
// ---------------------------------------------------------------------------
module dmem_addr_check #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              illegal
);

  // Only the word-index bits may be non-zero; any other set bit is either a
  // byte offset (misaligned) or an address beyond the top of the memory.
  localparam logic [ADDR_W-1:0] LEGAL_MASK =
    ((ADDR_W'(1) << IDX_W) - ADDR_W'(1)) << 2;

  assign illegal = |(addr & ~LEGAL_MASK);

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//   Shares a single-port, 1-cycle-latency data memory between the CPU
//   load/store port and an external (I/O / debug loader) port.
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   bus    slave modport of data_mem_arbiter_if (CPU, EXT and memory sides)
// Arbitration: CPU normally wins; once EXT has been refused MAX_WAIT
// consecutive cycles it gets one cycle of priority. Read data returns the
// cycle after the grant and is steered to whichever port issued the read.
// ---------------------------------------------------------------------------
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_arbiter_if.slave  bus
);

  // Wide enough to hold MAX_WAIT, the value reached on the hand-over cycle.
  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  arb_state_t        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  rd_owner_t         rd_owner_q, rd_owner_d;
  logic              addr_err_q, addr_err_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic              cpu_grant;
  logic              ext_grant;
  logic              cpu_rvalid;
  logic              ext_rvalid;

  // -------------------------------------------------------------------------
  // Address legality, one checker per requester (index 0 = CPU, 1 = EXT)
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] port_addr [2];
  logic [1:0]        port_bad;

  assign port_addr[0] = bus.cpu_addr;
  assign port_addr[1] = bus.ext_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_chk
    dmem_addr_check #(
      .ADDR_W (ADDR_W),
      .IDX_W  (IDX_W)
    ) u_chk (
      .addr    (port_addr[gi]),
      .illegal (port_bad[gi])
    );
  end

  // -------------------------------------------------------------------------
  // Arbitration FSM: next state, wait counter and grants
  // -------------------------------------------------------------------------
  always_comb begin
    cpu_grant  = 1'b0;
    ext_grant  = 1'b0;
    state_d    = state_q;
    wait_cnt_d = '0;
    // Nothing is granted while reset is high, so memory is never written.
    if (!reset) begin
      case (state_q)
        ARB_CPU: begin
          if (bus.cpu_req) begin
            cpu_grant = 1'b1;
          end else if (bus.ext_req) begin
            ext_grant = 1'b1;
          end
          if (bus.ext_req && !ext_grant) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            if (wait_cnt_q == WCNT_W'(MAX_WAIT - 1)) begin
              state_d = ARB_EXT;
            end
          end
        end
        ARB_EXT: begin
          // Priority slot for EXT; an idle slot is not wasted on the CPU.
          if (bus.ext_req) begin
            ext_grant = 1'b1;
          end else if (bus.cpu_req) begin
            cpu_grant = 1'b1;
          end
          state_d = ARB_CPU;
        end
        default: begin
          state_d = ARB_CPU;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read ownership, sticky error and held read data
  // -------------------------------------------------------------------------
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_grant && !bus.cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (ext_grant && !bus.ext_we) begin
      rd_owner_d = OWN_EXT;
    end

    addr_err_d = addr_err_q
               | (cpu_grant & port_bad[0])
               | (ext_grant & port_bad[1]);

    // A read that was in flight when reset rose is dropped.
    cpu_rvalid = !reset && (rd_owner_q == OWN_CPU);
    ext_rvalid = !reset && (rd_owner_q == OWN_EXT);

    cpu_rdata_d = cpu_rvalid ? bus.mem_read_data : cpu_rdata_q;
    ext_rdata_d = ext_rvalid ? bus.mem_read_data : ext_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_CPU;
      wait_cnt_q  <= '0;
      rd_owner_q  <= OWN_NONE;
      addr_err_q  <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rd_owner_q  <= rd_owner_d;
      addr_err_q  <= addr_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.cpu_stall      = bus.cpu_req & ~cpu_grant;
  assign bus.ext_gnt        = bus.ext_req & ext_grant;

  assign bus.mem_write      = (cpu_grant & bus.cpu_we) | (ext_grant & bus.ext_we);
  assign bus.mem_address    = cpu_grant ? bus.cpu_addr
                            : ext_grant ? bus.ext_addr
                            : '0;
  assign bus.mem_write_data = cpu_grant ? bus.cpu_wdata
                            : ext_grant ? bus.ext_wdata
                            : '0;

  assign bus.cpu_rvalid     = cpu_rvalid;
  assign bus.ext_rvalid     = ext_rvalid;
  // Same-cycle bypass so the data is presented in the rvalid cycle.
  assign bus.cpu_rdata      = cpu_rdata_d;
  assign bus.ext_rdata      = ext_rdata_d;
  assign bus.addr_err       = addr_err_q;

endmodule
